// File: rtl/blk_8d20ee.sv
// blk_8d20ee: OCI monitor RAM arbiter.
// Shares the single-port debug RAM between JTAG ocimem commands and the
// Avalon debug_mem slave, sequencing each access as IDLE/ISSUE/CAPTURE/DONE.
// Optional build macro: OCIMEM_ARB_AUTOINC_EN (post-increment MonAReg after
// every JTAG RAM access so block transfers need no address reload).
module blk_8d20ee #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic [31:0]       av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_be,
    output logic              ram_wr,
    output logic              ram_rd,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Registered state
    state_t            state_q, state_d;
    logic              owner_jtag_q, owner_jtag_d;   // who owns the current access
    logic              op_wr_q, op_wr_d;             // current access is a write
    logic              last_jtag_q, last_jtag_d;     // last grant went to JTAG
    logic              jpend_q, jpend_d;             // JTAG op waiting for a grant
    logic              jp_wr_q, jp_wr_d;
    logic [ADDR_W-1:0] jp_addr_q, jp_addr_d;
    logic [31:0]       jp_wdata_q, jp_wdata_d;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;             // MonAReg
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic [31:0]       mond_q, mond_d;
    logic [31:0]       avrd_q, avrd_d;
    logic              waitreq_q, waitreq_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic [3:0]        ram_be_q, ram_be_d;
    logic              ram_wr_q, ram_wr_d;
    logic              ram_rd_q, ram_rd_d;

    // Decoded JTAG command for this cycle
    logic              strobe_any;
    logic              accept;
    logic              new_op;
    logic              new_wr;
    logic [ADDR_W-1:0] jdo_addr;
    logic [ADDR_W-1:0] new_addr;
    logic              j_req;
    logic              av_req;
    logic              grant_j;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_be;

    // jdo bits that carry no meaning for the ocimem commands
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[34:ADDR_W+17]};

    // Decode the strobes (a beats b beats no_action) and pick the requester
    always_comb begin
        strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        accept     = strobe_any & ready_q;
        jdo_addr   = jdo[ADDR_W+16:17];
        new_op     = accept & (take_action_ocimem_a ? jdo[35] : 1'b1);
        new_wr     = ~take_action_ocimem_a & take_action_ocimem_b;
        new_addr   = take_action_ocimem_a ? jdo_addr : mon_a_q;
        j_req      = jpend_q | new_op;
        av_req     = av_read | av_write;
        grant_j    = j_req & (~av_req | ~last_jtag_q);
        if (grant_j) begin
            sel_wr    = jpend_q ? jp_wr_q    : new_wr;
            sel_addr  = jpend_q ? jp_addr_q  : new_addr;
            sel_wdata = jpend_q ? jp_wdata_q : jdo[31:0];
            sel_be    = 4'hF;
        end else begin
            sel_wr    = av_write;
            sel_addr  = av_address;
            sel_wdata = av_writedata;
            sel_be    = av_byteenable;
        end
    end

    // Next-state logic: RAM access sequencer plus JTAG command capture
    always_comb begin
        state_d      = state_q;
        owner_jtag_d = owner_jtag_q;
        op_wr_d      = op_wr_q;
        last_jtag_d  = last_jtag_q;
        jpend_d      = jpend_q;
        jp_wr_d      = jp_wr_q;
        jp_addr_d    = jp_addr_q;
        jp_wdata_d   = jp_wdata_q;
        mon_a_d      = mon_a_q;
        ready_d      = ready_q;
        err_d        = err_q;
        mond_d       = mond_q;
        avrd_d       = avrd_q;
        waitreq_d    = waitreq_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_be_d     = ram_be_q;
        ram_wr_d     = 1'b0;
        ram_rd_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (j_req | av_req) begin
                    state_d      = S_ISSUE;
                    owner_jtag_d = grant_j;
                    last_jtag_d  = grant_j;
                    op_wr_d      = sel_wr;
                    ram_addr_d   = sel_addr;
                    ram_wdata_d  = sel_wdata;
                    ram_be_d     = sel_be;
                    ram_wr_d     = sel_wr;
                    ram_rd_d     = ~sel_wr;
                    if (grant_j) begin
                        jpend_d = 1'b0;
                    end
                end
            end
            S_ISSUE: begin
                // Writes finish next cycle; reads wait one cycle for RAM data
                state_d = op_wr_q ? S_DONE : S_CAPTURE;
                if (op_wr_q && !owner_jtag_q) begin
                    waitreq_d = 1'b0;
                end
            end
            S_CAPTURE: begin
                state_d = S_DONE;
                if (owner_jtag_q) begin
                    mond_d = ram_rdata;
                end else begin
                    avrd_d    = ram_rdata;
                    waitreq_d = 1'b0;
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                waitreq_d = 1'b1;
                if (owner_jtag_q) begin
                    ready_d = 1'b1;
`ifdef OCIMEM_ARB_AUTOINC_EN
                    mon_a_d = mon_a_q + ADDR_ONE;
`else
                    mon_a_d = mon_a_q;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A strobe while a JTAG op is outstanding is lost and flagged
        if (strobe_any && !ready_q) begin
            err_d = 1'b1;
        end
        if (accept && take_action_ocimem_a) begin
            err_d   = 1'b0;
            mon_a_d = jdo_addr;
        end
        if (new_op) begin
            ready_d    = 1'b0;
            jp_wr_d    = new_wr;
            jp_addr_d  = new_addr;
            jp_wdata_d = jdo[31:0];
            // Park the op unless the sequencer took it straight away
            if (!(state_q == S_IDLE && grant_j)) begin
                jpend_d = 1'b1;
            end
        end
    end

    // State registers; reset drops any RAM strobe immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            owner_jtag_q <= 1'b0;
            op_wr_q      <= 1'b0;
            last_jtag_q  <= 1'b0;
            jpend_q      <= 1'b0;
            jp_wr_q      <= 1'b0;
            jp_addr_q    <= '0;
            jp_wdata_q   <= '0;
            mon_a_q      <= '0;
            ready_q      <= 1'b1;
            err_q        <= 1'b0;
            mond_q       <= '0;
            avrd_q       <= '0;
            waitreq_q    <= 1'b1;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_be_q     <= '0;
            ram_wr_q     <= 1'b0;
            ram_rd_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_jtag_q <= owner_jtag_d;
            op_wr_q      <= op_wr_d;
            last_jtag_q  <= last_jtag_d;
            jpend_q      <= jpend_d;
            jp_wr_q      <= jp_wr_d;
            jp_addr_q    <= jp_addr_d;
            jp_wdata_q   <= jp_wdata_d;
            mon_a_q      <= mon_a_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
            mond_q       <= mond_d;
            avrd_q       <= avrd_d;
            waitreq_q    <= waitreq_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_be_q     <= ram_be_d;
            ram_wr_q     <= ram_wr_d;
            ram_rd_q     <= ram_rd_d;
        end
    end

    assign av_readdata    = avrd_q;
    assign av_waitrequest = waitreq_q;
    assign ram_addr       = ram_addr_q;
    assign ram_wdata      = ram_wdata_q;
    assign ram_be         = ram_be_q;
    assign ram_wr         = ram_wr_q;
    assign ram_rd         = ram_rd_q;
    assign MonDReg        = mond_q;
    assign monitor_ready  = ready_q;
    assign monitor_error  = err_q;

endmodule
